bus_cycle_ctrl: RTL and testbench
=================================

Name: bus_cycle_ctrl

Overview: Sequences every 68000 bus cycle in the CPLD. It decodes the address region and drives the chip selects and strobes. It inserts per-region wait states, generates DTACK_n, and raises BERR_n on unmapped or stalled cycles. It runs on the same clock that the main clock divider uses to derive the CPU clock, so all CPU strobes are synchronous to clk_in.

Parameters:
ROM_WS, 2, wait states inserted for ROM cycles (0..15)
RAM_WS, 0, wait states inserted for RAM cycles (0..15)
IO_WS, 4, minimum wait states for IO cycles (0..15)
TIMEOUT, 64, clk_in cycles from cycle start to bus error (16..255)

Ports:
clk_in  in  1  system clock
reset  in  1  synchronous active-high reset
as_n  in  1  CPU address strobe, active low
uds_n  in  1  upper data strobe, active low
lds_n  in  1  lower data strobe, active low
rw  in  1  1 = read, 0 = write
addr_hi  in  4  CPU A23..A20
io_wait_n  in  1  IO device wait request, active low
rom_cs_n  out  1  ROM select
ram_cs_n  out  1  RAM select
io_cs_n  out  1  IO select
oe_n  out  1  read output enable
we_hi_n  out  1  write strobe, D15..D8
we_lo_n  out  1  write strobe, D7..D0
dtack_n  out  1  data transfer acknowledge to CPU
berr_n  out  1  bus error to CPU

Behaviour:
- Clock and reset: one clock, clk_in. reset is synchronous and active-high. At reset: all outputs go to 1, the state goes to IDLE, and the boot overlay flag is set to 1.
- All outputs are registered. Inputs are sampled directly, because they are synchronous to clk_in.
- Address decode (combinational, sampled at the start edge):
  - addr_hi 0x0..0x7 → RAM; when the boot flag is 1, reads (rw = 1) of 0x0 → ROM instead.
  - 0xE → ROM.
  - 0xF → IO.
  - 0x8..0xD → UNMAPPED.
- Boot overlay flag: cleared at the start edge of the first cycle that decodes to addr_hi 0xE. It stays cleared until the next reset.
- States: IDLE, WAIT, ACK, TOUT, BERR.
- IDLE:
  - Edge E0 with as_n = 0 → latch the region.
  - Mapped region: the matching cs_n goes low, wait counter wc = region WS, timeout counter tc = 0, go to WAIT.
  - UNMAPPED: no cs, tc = 0, go to TOUT.
- Strobes while a cs is active:
  - oe_n = !rw.
  - we_hi_n = !(~rw & ~uds_n) and we_lo_n = !(~rw & ~lds_n).
  - Re-evaluated every cycle, so a late data strobe on writes is honoured.
- WAIT:
  - wc > 0 → wc decrements.
  - wc = 0 and (region ≠ IO or io_wait_n = 1) → go to ACK; dtack_n goes low on that edge.
  - tc increments every cycle; tc reaching TOUT−1 → go to BERR.
  - Mapped latency: dtack_n is low after edge E(WS+1). RAM with WS = 0 → dtack_n low after E1.
- TOUT: tc increments each cycle; tc = TOUT−1 → go to BERR, berr_n goes low.
- ACK / BERR: hold dtack_n (ACK) or berr_n (BERR) low until an edge samples as_n = 1. On that edge, release all outputs to 1 and go to IDLE.
- Abort: as_n = 1 sampled in WAIT or TOUT → release all outputs and go to IDLE. No dtack_n, no berr_n.
- Back-to-back cycles: a new cycle is accepted only from IDLE. as_n low on the same edge that returns the block to IDLE is not accepted; as_n is re-sampled on the next edge. This guarantees at least one idle cycle between cycles.
- dtack_n and berr_n are never low together. Only one cs_n is low at any time.
- reset asserted mid-cycle: all outputs go to 1 at that edge, the state goes to IDLE, and the boot flag is set.
- Counters: wc is 4 bits; tc is 8 bits and saturates, so it never wraps.

Test Plan:
- Boot vector fetch: after reset, read addr_hi = 0x0 → rom_cs_n low at E0, oe_n low, dtack_n low after E3 (ROM_WS = 2). Boot flag still 1.
- Overlay clear: read addr_hi = 0xE, then read addr_hi = 0x0 → second cycle asserts ram_cs_n, and dtack_n is low after E1.
- Byte write RAM: rw = 0, uds_n = 1, lds_n = 0, addr_hi = 0x2 → we_lo_n low, we_hi_n high, oe_n high, dtack_n low after E1. All outputs high one edge after as_n rises.
- IO stretch: addr_hi = 0xF with io_wait_n low for 10 cycles → dtack_n low only the edge after io_wait_n rises, never before E5. With io_wait_n held low → berr_n low after E63 and dtack_n stays high.
- Unmapped: addr_hi = 0x9 → no cs, berr_n low after E63, released one edge after as_n rises.
- Abort and reset: as_n rises during the 2nd ROM wait cycle → idle with no dtack_n. A separate cycle with reset pulsed mid-WAIT → all outputs 1 on the next edge, and the next 0x0 read selects ROM again.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 68000 bus cycle sequencer with region decode, wait states, DTACK and bus-error generation
module bus_cycle_ctrl #(
  parameter int ROM_WS  = 2,
  parameter int RAM_WS  = 0,
  parameter int IO_WS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       as_n,
  input  logic       uds_n,
  input  logic       lds_n,
  input  logic       rw,
  input  logic [3:0] addr_hi,
  input  logic       io_wait_n,
  output logic       rom_cs_n,
  output logic       ram_cs_n,
  output logic       io_cs_n,
  output logic       oe_n,
  output logic       we_hi_n,
  output logic       we_lo_n,
  output logic       dtack_n,
  output logic       berr_n
);
  typedef enum logic [2:0] {IDLE, WAIT, ACK, TOUT, BERR} state_t;
  typedef enum logic [1:0] {R_RAM, R_ROM, R_IO, R_NONE} region_t;
  localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);
  state_t     state, state_d;
  region_t    region, region_d, dec;
  logic [3:0] wc, wc_d, ws;
  logic [7:0] tc, tc_d, tc_inc;
  logic       boot, boot_d, act;
  logic       rom_cs_d, ram_cs_d, io_cs_d, oe_d, we_hi_d, we_lo_d, dtack_d, berr_d;
  always_comb begin
    dec = !addr_hi[3] ? ((boot && rw && addr_hi == 4'h0) ? R_ROM : R_RAM) :
          addr_hi == 4'hE ? R_ROM : addr_hi == 4'hF ? R_IO : R_NONE;
    ws = dec == R_ROM ? 4'(ROM_WS) : dec == R_RAM ? 4'(RAM_WS) : 4'(IO_WS);
    tc_inc = tc == 8'hFF ? tc : tc + 8'd1;
    state_d = state;
    region_d = region;
    wc_d = wc;
    tc_d = tc;
    boot_d = boot;
    case (state)
      IDLE: if (!as_n) begin
        region_d = dec;
        wc_d = ws;
        tc_d = 8'd0;
        boot_d = boot && addr_hi != 4'hE;
        state_d = dec == R_NONE ? TOUT : WAIT;
      end
      WAIT: if (as_n) state_d = IDLE;
      else begin
        tc_d = tc_inc;
        wc_d = wc != 4'd0 ? wc - 4'd1 : wc;
        state_d = (wc == 4'd0 && (region != R_IO || io_wait_n)) ? ACK :
                  tc_inc == TC_LAST ? BERR : WAIT;
      end
      TOUT: if (as_n) state_d = IDLE;
      else begin
        tc_d = tc_inc;
        state_d = tc_inc == TC_LAST ? BERR : TOUT;
      end
      ACK, BERR: state_d = as_n ? IDLE : state;
      default: state_d = IDLE;
    endcase
    // strobes follow the live data strobes every cycle a select is held
    act = (state_d == WAIT || state_d == ACK || state_d == BERR) && region_d != R_NONE;
    rom_cs_d = !(act && region_d == R_ROM);
    ram_cs_d = !(act && region_d == R_RAM);
    io_cs_d = !(act && region_d == R_IO);
    oe_d = !(act && rw);
    we_hi_d = !(act && !rw && !uds_n);
    we_lo_d = !(act && !rw && !lds_n);
    dtack_d = state_d != ACK;
    berr_d = state_d != BERR;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      region <= R_NONE;
      wc <= 4'd0;
      tc <= 8'd0;
      boot <= 1'b1;
      {rom_cs_n, ram_cs_n, io_cs_n, oe_n, we_hi_n, we_lo_n, dtack_n, berr_n} <= 8'hFF;
    end else begin
      state <= state_d;
      region <= region_d;
      wc <= wc_d;
      tc <= tc_d;
      boot <= boot_d;
      {rom_cs_n, ram_cs_n, io_cs_n, oe_n, we_hi_n, we_lo_n, dtack_n, berr_n} <=
        {rom_cs_d, ram_cs_d, io_cs_d, oe_d, we_hi_d, we_lo_d, dtack_d, berr_d};
    end
  end
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed scoreboard bench for bus_cycle_ctrl at default parameters
module tb_bus_cycle_ctrl;
  logic clk_in = 1'b0, reset = 1'b1;
  logic as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1, io_wait_n = 1'b1;
  logic [3:0] addr_hi = 4'h0;
  logic rom_cs_n, ram_cs_n, io_cs_n, oe_n, we_hi_n, we_lo_n, dtack_n, berr_n;
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  string tag_q[$];
  // output vector order: {rom,ram,io,oe,we_hi,we_lo,dtack,berr}, all active low
  localparam logic [7:0] IDLE_V = 8'hFF;
  localparam logic [7:0] ROM_RD = 8'b0110_1111, ROM_ACK = 8'b0110_1101;
  localparam logic [7:0] RAM_RD = 8'b1010_1111, RAM_ACK = 8'b1010_1101;
  localparam logic [7:0] RAM_WN = 8'b1011_1111, RAM_WLO_ACK = 8'b1011_1001;
  localparam logic [7:0] RAM_WLO = 8'b1011_1011;
  localparam logic [7:0] IO_RD = 8'b1100_1111, IO_ACK = 8'b1100_1101, IO_BERR = 8'b1100_1110;
  localparam logic [7:0] UNM_BERR = 8'b1111_1110;

  bus_cycle_ctrl dut (
    .clk_in(clk_in), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
    .addr_hi(addr_hi), .io_wait_n(io_wait_n), .rom_cs_n(rom_cs_n), .ram_cs_n(ram_cs_n),
    .io_cs_n(io_cs_n), .oe_n(oe_n), .we_hi_n(we_hi_n), .we_lo_n(we_lo_n),
    .dtack_n(dtack_n), .berr_n(berr_n)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input string tag, input logic [7:0] e);
    logic [7:0] got, want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_in);
    #1;
    got = {rom_cs_n, ram_cs_n, io_cs_n, oe_n, we_hi_n, we_lo_n, dtack_n, berr_n};
    want = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", t, got, want);
    end
    checks++;
    assert ((dtack_n | berr_n) === 1'b1) else begin
      failures++;
      $error("FAIL %s_excl: observed dtack_n=%b berr_n=%b expected not both low", t, dtack_n, berr_n);
    end
    @(negedge clk_in);
  endtask

  task automatic start(input logic r, input logic u, input logic l, input logic [3:0] a);
    as_n = 1'b0; rw = r; uds_n = u; lds_n = l; addr_hi = a;
  endtask

  task automatic release_bus(input string tag);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    tick(tag, IDLE_V);
    tick({tag, "_idle"}, IDLE_V);
  endtask

  initial begin
    @(negedge clk_in);
    tick("reset0", IDLE_V);
    tick("reset1", IDLE_V);
    reset = 1'b0;
    tick("idle", IDLE_V);
    start(1, 0, 0, 4'h0);
    tick("boot_e0", ROM_RD);
    tick("boot_e1", ROM_RD);
    tick("boot_e2", ROM_RD);
    tick("boot_e3", ROM_ACK);
    release_bus("boot_rel");
    start(1, 0, 0, 4'h0);
    tick("boot_still", ROM_RD);
    release_bus("boot_abort");
    start(1, 0, 0, 4'hE);
    tick("rom_e0", ROM_RD);
    tick("rom_e1", ROM_RD);
    tick("rom_e2", ROM_RD);
    tick("rom_e3", ROM_ACK);
    release_bus("rom_rel");
    start(1, 0, 0, 4'h0);
    tick("ovl_e0", RAM_RD);
    tick("ovl_e1", RAM_ACK);
    release_bus("ovl_rel");
    start(0, 1, 0, 4'h2);
    tick("bw_e0", RAM_WLO);
    tick("bw_e1", RAM_WLO_ACK);
    release_bus("bw_rel");
    start(0, 1, 1, 4'h1);
    tick("late_e0", RAM_WN);
    lds_n = 1'b0;
    tick("late_e1", RAM_WLO_ACK);
    release_bus("late_rel");
    start(1, 0, 0, 4'hF);
    tick("io_min_e0", IO_RD);
    for (int i = 1; i <= 4; i++) tick($sformatf("io_min_e%0d", i), IO_RD);
    tick("io_min_e5", IO_ACK);
    release_bus("io_min_rel");
    start(1, 0, 0, 4'hF);
    io_wait_n = 1'b0;
    tick("io_st_e0", IO_RD);
    for (int i = 1; i <= 10; i++) tick($sformatf("io_st_e%0d", i), IO_RD);
    io_wait_n = 1'b1;
    tick("io_st_e11", IO_ACK);
    release_bus("io_st_rel");
    start(1, 0, 0, 4'hF);
    io_wait_n = 1'b0;
    tick("io_to_e0", IO_RD);
    for (int i = 1; i <= 62; i++) tick($sformatf("io_to_e%0d", i), IO_RD);
    tick("io_to_e63", IO_BERR);
    tick("io_to_hold", IO_BERR);
    io_wait_n = 1'b1;
    release_bus("io_to_rel");
    start(1, 0, 0, 4'h9);
    for (int i = 0; i <= 62; i++) tick($sformatf("unm_e%0d", i), IDLE_V);
    tick("unm_e63", UNM_BERR);
    tick("unm_hold", UNM_BERR);
    release_bus("unm_rel");
    start(1, 0, 0, 4'hE);
    tick("ab_e0", ROM_RD);
    tick("ab_e1", ROM_RD);
    as_n = 1'b1;
    tick("ab_e2", IDLE_V);
    tick("ab_e3", IDLE_V);
    tick("ab_e4", IDLE_V);
    start(1, 0, 0, 4'hE);
    tick("rst_e0", ROM_RD);
    reset = 1'b1;
    tick("rst_mid", IDLE_V);
    reset = 1'b0;
    as_n = 1'b1;
    tick("rst_idle", IDLE_V);
    start(1, 0, 0, 4'h0);
    tick("rst_boot_e0", ROM_RD);
    tick("rst_boot_e1", ROM_RD);
    tick("rst_boot_e2", ROM_RD);
    tick("rst_boot_e3", ROM_ACK);
    release_bus("rst_boot_rel");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
